maglev_adc_sampler: RTL and testbench

MAGLEV_ADC_SAMPLER -- requirements
Module: maglev_adc_sampler

---
 rtl/maglev_pkg.sv | 25 ++
 rtl/maglev_spi_clkgen.sv | 37 +++
 rtl/maglev_adc_sampler.sv | 137 +++++++++++++
 tb/tb_maglev_adc_sampler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maglev_pkg.sv
// Shared definitions for the maglev ADC sampler: FSM state encoding, frame sizes
// and the SPI configuration word layout.
package maglev_pkg;

  localparam int ADC_BITS       = 12;
  localparam int SPI_FRAME_BITS = 16;

  // Config word: start bit, 3-bit channel, 2-bit mode tail, then zero padding.
  localparam logic       CFG_START_BIT = 1'b1;
  localparam logic [1:0] CFG_MODE_TAIL = 2'b10;
  localparam int         CFG_PAD_BITS  = SPI_FRAME_BITS - 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } adc_state_e;

  function automatic logic [SPI_FRAME_BITS-1:0] cfg_word(input logic [2:0] chan);
    return {CFG_START_BIT, chan, CFG_MODE_TAIL, {CFG_PAD_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/maglev_spi_clkgen.sv
// SCLK phase generator: counts CLK_DIV cycles per half-period while run is high and
// toggles sclk only while shift_en is high, so SETUP/HOLD reuse the same timer.
module maglev_spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic shift_en,
  output logic sclk,
  output logic half_tick,
  output logic rise_tick,
  output logic fall_tick
);

  logic [7:0] div_cnt;

  // Ticks mark the last clk cycle of a half-period; the edge happens on the next clk edge.
  assign half_tick = run && (div_cnt == 8'(CLK_DIV - 1));
  assign rise_tick = half_tick && shift_en && !sclk;
  assign fall_tick = half_tick && shift_en && sclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else begin
      if (half_tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 8'd1;
      if (half_tick && shift_en) sclk <= !sclk;
    end
  end

endmodule

// File: rtl/maglev_adc_sampler.sv
// Periodic SPI ADC sampler: one 16-clock frame per trigger, result published on sample_out.
// Optional build macro MAGLEV_ADC_AVG_EN publishes a 4-sample running average instead of raw data.
module maglev_adc_sampler
  import maglev_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 5000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [2:0]  channel,
  input  logic        adc_miso,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic        adc_mosi,
  output logic [15:0] sample_out,
  output logic        sample_strobe,
  output logic        overrun,
  output adc_state_e  dbg_state
);

  localparam int                CNT_W      = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SAMPLE_PERIOD - 1);

  adc_state_e                state, state_nxt;
  logic [CNT_W-1:0]          period_cnt;
  logic                      trigger;
  logic [2:0]                chan_q;
  logic [3:0]                bit_cnt;
  logic [ADC_BITS-1:0]       shift_q;
  logic [ADC_BITS-1:0]       data_field;
  logic                      toggle_q;
  logic [15:0]               sample_q;
  logic                      strobe_q;
  logic                      overrun_q;
  logic [SPI_FRAME_BITS-1:0] frame_word;
  logic                      run, shift_en, half_tick, rise_tick, fall_tick, sclk;

  // Free-running period counter; enable only gates whether its wrap becomes a trigger.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              period_cnt <= CNT_RELOAD;
    else if (period_cnt == '0) period_cnt <= CNT_RELOAD;
    else                       period_cnt <= period_cnt - 1'b1;
  end

  assign trigger  = (period_cnt == '0) && enable;
  assign run      = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign shift_en = (state == ST_SHIFT);

  maglev_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .shift_en  (shift_en),
    .sclk      (sclk),
    .half_tick (half_tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (trigger) state_nxt = ST_SETUP;
      ST_SETUP: if (half_tick) state_nxt = ST_SHIFT;
      ST_SHIFT: if (fall_tick && (bit_cnt == 4'd15)) state_nxt = ST_HOLD;
      ST_HOLD:  if (half_tick) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

`ifdef MAGLEV_ADC_AVG_EN
  logic [ADC_BITS-1:0] hist1_q, hist2_q, hist3_q;
  logic [13:0]         avg_sum;

  assign avg_sum    = 14'(shift_q) + 14'(hist1_q) + 14'(hist2_q) + 14'(hist3_q);
  assign data_field = avg_sum[13:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist1_q <= '0;
      hist2_q <= '0;
      hist3_q <= '0;
    end else if (state == ST_DONE) begin
      hist1_q <= shift_q;
      hist2_q <= hist1_q;
      hist3_q <= hist2_q;
    end
  end
`else
  assign data_field = shift_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_q    <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      toggle_q  <= 1'b0;
      sample_q  <= '0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      strobe_q  <= 1'b0;
      overrun_q <= trigger && (state != ST_IDLE);
      if ((state == ST_IDLE) && trigger) begin
        chan_q  <= channel;
        bit_cnt <= '0;
      end
      // Only the first 12 rising edges carry conversion data; the trailing 4 are discarded.
      if (rise_tick && (bit_cnt < 4'd12)) shift_q <= {shift_q[ADC_BITS-2:0], adc_miso};
      if (fall_tick) bit_cnt <= bit_cnt + 4'd1;
      if (state == ST_DONE) begin
        sample_q <= {chan_q, !toggle_q, data_field};
        toggle_q <= !toggle_q;
        strobe_q <= 1'b1;
      end
    end
  end

  assign frame_word    = cfg_word(chan_q);
  assign adc_mosi      = (state == ST_SHIFT) ? frame_word[4'd15 - bit_cnt] : 1'b0;
  assign adc_cs_n      = !((state == ST_SETUP) || (state == ST_SHIFT));
  assign adc_sclk      = sclk;
  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign overrun       = overrun_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_maglev_adc_sampler.sv
// Directed bench for maglev_adc_sampler: a period-200 instance for the main function and
// reset/enable corners, plus a period-64 instance that must drop every second trigger.
module tb_maglev_adc_sampler;
  import maglev_pkg::*;

  localparam int CLK_DIV    = 2;
  localparam int PERIOD     = 200;
  localparam int PERIOD_OVR = 64;
  localparam int CS_TO_STB  = 34 * CLK_DIV + 1;  // cs_n falls one cycle after the trigger

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable, adc_miso, adc_sclk, adc_cs_n, adc_mosi, sample_strobe, overrun;
  logic [2:0]  channel;
  logic [15:0] sample_out;
  adc_state_e  dbg_state;

  logic        rst2_n, enable2, adc_miso2, adc_sclk2, adc_cs_n2, adc_mosi2, sample_strobe2, overrun2;
  logic [2:0]  channel2;
  logic [15:0] sample_out2;
  adc_state_e  dbg_state2;

  maglev_adc_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(PERIOD)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .channel(channel), .adc_miso(adc_miso),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_mosi(adc_mosi), .sample_out(sample_out),
    .sample_strobe(sample_strobe), .overrun(overrun), .dbg_state(dbg_state)
  );

  maglev_adc_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(PERIOD_OVR)) dut_ovr (
    .clk(clk), .reset_n(rst2_n), .enable(enable2), .channel(channel2), .adc_miso(adc_miso2),
    .adc_sclk(adc_sclk2), .adc_cs_n(adc_cs_n2), .adc_mosi(adc_mosi2), .sample_out(sample_out2),
    .sample_strobe(sample_strobe2), .overrun(overrun2), .dbg_state(dbg_state2)
  );

  // ---------------- ADC models ----------------
  function automatic logic miso_bit(input logic [11:0] d, input int idx);
    if (idx < 12) return d[11 - idx];
    return 1'b0;
  endfunction

  logic [11:0] adc_data  = 12'h000;
  logic [11:0] adc_data2 = 12'h3C1;
  int          rise_cnt  = 0;
  int          rise_cnt2 = 0;
  logic [15:0] mosi_frame = 16'h0000;

  assign adc_miso  = miso_bit(adc_data, rise_cnt);
  assign adc_miso2 = miso_bit(adc_data2, rise_cnt2);

  always @(negedge adc_cs_n or posedge adc_sclk) begin
    if (adc_sclk) begin
      mosi_frame = {mosi_frame[14:0], adc_mosi};
      rise_cnt   = rise_cnt + 1;
    end else begin
      mosi_frame = 16'h0000;
      rise_cnt   = 0;
    end
  end

  always @(negedge adc_cs_n2 or posedge adc_sclk2) begin
    if (adc_sclk2) rise_cnt2 = rise_cnt2 + 1;
    else           rise_cnt2 = 0;
  end

  // ---------------- event counters ----------------
  int cyc = 0, ovr1_cnt = 0, ovr2_cnt = 0, stb2_cnt = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (overrun)        ovr1_cnt = ovr1_cnt + 1;
    if (overrun2)       ovr2_cnt = ovr2_cnt + 1;
    if (sample_strobe2) stb2_cnt = stb2_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver / wait tasks ----------------
  task automatic wait_cs_fall(input int limit, output bit ok);
    logic prev;
    prev = adc_cs_n;
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (prev && !adc_cs_n) begin
        ok = 1'b1;
        break;
      end
      prev = adc_cs_n;
    end
  endtask

  task automatic wait_strobe(input bit which, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if ((which ? sample_strobe2 : sample_strobe) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
    logic [15:0] exp_out;
    logic [15:0] exp_mosi;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit          ok;
    int          t_cs, last_cs, t_stb, ov0, bad, cs_edges;
    logic        prev_cs;
    logic [15:0] exp_en, exp_rst;

`ifdef MAGLEV_ADC_AVG_EN
    vecs[0] = '{3'd3, 12'd400,  16'h7064, 16'hB800};
    vecs[1] = '{3'd3, 12'd800,  16'h612C, 16'hB800};
    vecs[2] = '{3'd3, 12'd1200, 16'h7258, 16'hB800};
    vecs[3] = '{3'd3, 12'd1600, 16'h63E8, 16'hB800};
    exp_en  = 16'h33C0;  // (240+1600+1200+800)/4 = 960
    exp_rst = 16'h7297;  // history cleared: 0xA5C/4
`else
    vecs[0] = '{3'd3, 12'hA5C, 16'h7A5C, 16'hB800};
    vecs[1] = '{3'd5, 12'h123, 16'hA123, 16'hD800};
    vecs[2] = '{3'd0, 12'hFFF, 16'h1FFF, 16'h8800};
    vecs[3] = '{3'd7, 12'h000, 16'hE000, 16'hF800};
    exp_en  = 16'h30F0;
    exp_rst = 16'h7A5C;
`endif

    reset_n  = 1'b0;
    rst2_n   = 1'b0;
    enable   = 1'b0;
    enable2  = 1'b1;
    channel  = 3'd0;
    channel2 = 3'd2;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cs_n",    32'(adc_cs_n), 32'd1);
    check("rst_sclk",    32'(adc_sclk), 32'd0);
    check("rst_mosi",    32'(adc_mosi), 32'd0);
    check("rst_sample",  32'(sample_out), 32'd0);
    check("rst_strobe",  32'(sample_strobe), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state",   32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    rst2_n  = 1'b1;

    // Table-driven conversions; channel changes mid-frame for the next vector
    channel  = vecs[0].ch;
    adc_data = vecs[0].data;
    enable   = 1'b1;
    last_cs  = 0;
    for (int i = 0; i < 4; i++) begin
      wait_cs_fall(300, ok);
      check("vec_cs_fall", 32'(ok), 32'd1);
      t_cs = cyc;
      if (i > 0) check("vec_trigger_spacing", 32'(t_cs - last_cs), 32'(PERIOD));
      last_cs = t_cs;
      repeat (6) @(negedge clk);
      channel = (i < 3) ? vecs[i + 1].ch : 3'd6;
      wait_strobe(1'b0, 120, ok);
      check("vec_strobe_seen", 32'(ok), 32'd1);
      check("vec_latency",     32'(cyc - t_cs), 32'(CS_TO_STB));
      check("vec_sample_out",  32'(sample_out), 32'(vecs[i].exp_out));
      check("vec_mosi_frame",  32'(mosi_frame), 32'(vecs[i].exp_mosi));
      @(negedge clk);
      check("vec_strobe_pulse", 32'(sample_strobe), 32'd0);
      check("vec_sample_held",  32'(sample_out), 32'(vecs[i].exp_out));
      if (i < 3) adc_data = vecs[i + 1].data;
    end

    // Enable dropped during SHIFT: sample still published, no further frames
    channel  = 3'd1;
    adc_data = 12'h0F0;
    wait_cs_fall(300, ok);
    check("en_cs_fall", 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    check("en_in_shift", 32'(dbg_state), 32'(ST_SHIFT));
    enable = 1'b0;
    wait_strobe(1'b0, 120, ok);
    check("en_strobe_seen", 32'(ok), 32'd1);
    check("en_sample_out",  32'(sample_out), 32'(exp_en));
    cs_edges = 0;
    prev_cs  = adc_cs_n;
    for (int n = 0; n < 450; n++) begin
      @(negedge clk);
      if (prev_cs != adc_cs_n) cs_edges++;
      prev_cs = adc_cs_n;
    end
    check("en_no_cs_activity", 32'(cs_edges), 32'd0);

    // Async reset at SCLK period 7 aborts the frame immediately
    channel  = 3'd3;
    adc_data = 12'hA5C;
    enable   = 1'b1;
    wait_cs_fall(300, ok);
    check("rstmid_cs_fall", 32'(ok), 32'd1);
    repeat (CLK_DIV + 7 * 2 * CLK_DIV + 1) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rstmid_cs_n",  32'(adc_cs_n), 32'd1);
    check("rstmid_sclk",  32'(adc_sclk), 32'd0);
    check("rstmid_mosi",  32'(adc_mosi), 32'd0);
    check("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rstmid_sample_cleared", 32'(sample_out), 32'd0);
    bad = 0;
    ok  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sample_strobe) begin
        ok = 1'b1;
        break;
      end
      if (sample_out != 16'h0000) bad++;
    end
    check("rstmid_strobe_seen", 32'(ok), 32'd1);
    check("rstmid_held_zero",   32'(bad), 32'd0);
    check("rstmid_sample_out",  32'(sample_out), 32'(exp_rst));

    // Period 64 instance: every second trigger dropped, samples every 128 cycles
    wait_strobe(1'b1, 300, ok);
    check("ovr_first_strobe", 32'(ok), 32'd1);
    t_stb = cyc;
    ov0   = ovr2_cnt;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(1'b1, 200, ok);
      check("ovr_strobe_seen",    32'(ok), 32'd1);
      check("ovr_strobe_spacing", 32'(cyc - t_stb), 32'(2 * PERIOD_OVR));
      check("ovr_pulses_between", 32'(ovr2_cnt - ov0), 32'd1);
`ifdef MAGLEV_ADC_AVG_EN
      check("ovr_sample_hdr", 32'(sample_out2[15:12]), (stb2_cnt % 2 == 0) ? 32'h5 : 32'h4);
`else
      check("ovr_sample_out", 32'(sample_out2), (stb2_cnt % 2 == 0) ? 32'h53C1 : 32'h43C1);
`endif
      t_stb = cyc;
      ov0   = ovr2_cnt;
    end

    check("no_overrun_main", 32'(ovr1_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
